// File: rtl/bus_bit_router_if.sv
// Source / sink / config bundle for bus_bit_router.
// master: producer-and-consumer side (drives source, config and sink ready).
// slave : router side.
interface bus_bit_router_if #(
    parameter int WIDTH      = 2,
    parameter int N_SINKS    = 2,
    parameter int SEL_W      = 1,
    parameter int DROP_CNT_W = 8
);
    logic                       cfg_we;
    logic [SEL_W-1:0]           cfg_sel;
    logic [WIDTH-1:0]           cfg_mask;
    logic                       src_valid;
    logic                       src_ready;
    logic [WIDTH-1:0]           src_data;
    logic [N_SINKS-1:0]         snk_valid;
    logic [N_SINKS-1:0]         snk_ready;
    logic [N_SINKS*WIDTH-1:0]   snk_data;
    logic [DROP_CNT_W-1:0]      drop_count;

    modport master (
        output cfg_we, cfg_sel, cfg_mask, src_valid, src_data, snk_ready,
        input  src_ready, snk_valid, snk_data, drop_count
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_mask, src_valid, src_data, snk_ready,
        output src_ready, snk_valid, snk_data, drop_count
    );
endinterface

// File: rtl/bus_bit_router.sv
// bus_bit_router: registered bit-slice router. Each sink owns a runtime
// programmable route mask; masked source bits are copied into that sink's
// output register with a valid/ready handshake per sink.
// Optional build macro BUS_BIT_ROUTER_ZERO_FILL_EN: when defined, a load
// clears the unmasked bits of the sink register instead of holding them.
module bus_bit_router #(
    parameter int WIDTH      = 2,
    parameter int N_SINKS    = 2,
    parameter int SEL_W      = 1,
    parameter int DROP_CNT_W = 8,
    parameter logic [N_SINKS*WIDTH-1:0] RESET_MAP = {2'b01, 2'b10}
) (
    input logic             clk,
    input logic             rst_n,
    bus_bit_router_if.slave bus
);

    logic [WIDTH-1:0]      mask_q  [N_SINKS];
    logic [WIDTH-1:0]      data_p1 [N_SINKS];
    logic [N_SINKS-1:0]    vld_p1;
    logic [N_SINKS-1:0]    part;
    logic [N_SINKS-1:0]    busy;
    logic [DROP_CNT_W-1:0] drop_q;
    logic                  src_ready;
    logic                  xfer;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A sink participates when its mask is non-zero; it blocks the source
    // only while it participates and holds an unconsumed word.
    always_comb begin
        part = '0;
        busy = '0;
        for (int s = 0; s < N_SINKS; s++) begin
            part[s] = |mask_q[s];
            busy[s] = part[s] & vld_p1[s] & ~bus.snk_ready[s];
        end
    end

    assign src_ready = ~|busy;
    assign xfer      = bus.src_valid & src_ready;

    // Route masks: reset map, then per-sink writes; out-of-range selects match nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < N_SINKS; s++) begin
                mask_q[s] <= RESET_MAP[s*WIDTH +: WIDTH];
            end
        end else if (bus.cfg_we) begin
            for (int s = 0; s < N_SINKS; s++) begin
                if (bus.cfg_sel == SEL_W'(s)) begin
                    mask_q[s] <= bus.cfg_mask;
                end
            end
        end
    end

    // ---- stage p1: per-sink output registers (load on transfer, drain on ready)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= '0;
            for (int s = 0; s < N_SINKS; s++) begin
                data_p1[s] <= '0;
            end
        end else begin
            for (int s = 0; s < N_SINKS; s++) begin
                if (xfer && part[s]) begin
                    vld_p1[s]  <= 1'b1;
`ifdef BUS_BIT_ROUTER_ZERO_FILL_EN
                    data_p1[s] <= bus.src_data & mask_q[s];
`else
                    data_p1[s] <= (data_p1[s] & ~mask_q[s]) | (bus.src_data & mask_q[s]);
`endif
                end else if (vld_p1[s] && bus.snk_ready[s]) begin
                    vld_p1[s]  <= 1'b0;
                end
            end
        end
    end

    // Count words accepted while no sink participates (they go nowhere).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (xfer && !(|part)) begin
            drop_q <= sat_inc(drop_q);
        end
    end

    assign bus.src_ready  = src_ready;
    assign bus.snk_valid  = vld_p1;
    assign bus.drop_count = drop_q;

    for (genvar s = 0; s < N_SINKS; s++) begin : g_out
        assign bus.snk_data[s*WIDTH +: WIDTH] = data_p1[s];
    end

endmodule

// File: tb/tb_bus_bit_router.sv
// Testbench for bus_bit_router: directed scenarios plus randomized traffic,
// checked by a queue-based scoreboard fed from a behavioural reference model.
module tb_bus_bit_router;
    localparam int W   = 2;
    localparam int N   = 2;
    localparam int SW  = 1;
    localparam int DCW = 2;
    localparam logic [N*W-1:0] RMAP = {2'b01, 2'b10};
`ifdef BUS_BIT_ROUTER_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bus_bit_router_if #(.WIDTH(W), .N_SINKS(N), .SEL_W(SW), .DROP_CNT_W(DCW)) bus();

    bus_bit_router #(
        .WIDTH(W), .N_SINKS(N), .SEL_W(SW), .DROP_CNT_W(DCW), .RESET_MAP(RMAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state
    logic [W-1:0]   mmask [N];
    logic [W-1:0]   mdata [N];
    logic [N-1:0]   mvld;
    logic [DCW-1:0] mdrop;
    logic [W-1:0]   exp_q [N][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < N; s++) begin
            mmask[s] = RMAP[s*W +: W];
            mdata[s] = '0;
            exp_q[s].delete();
        end
        mvld  = '0;
        mdrop = '0;
    endtask

    function automatic logic [W-1:0] load_word(input logic [W-1:0] old, input logic [W-1:0] src,
                                               input logic [W-1:0] m);
        return ZF ? (src & m) : ((old & ~m) | (src & m));
    endfunction

    // Source may proceed unless some sink with a non-zero mask is full and stalled.
    function automatic logic exp_src_ready();
        logic r;
        r = 1'b1;
        for (int s = 0; s < N; s++) begin
            if (mmask[s] != '0 && mvld[s] && !bus.snk_ready[s]) r = 1'b0;
        end
        return r;
    endfunction

    // Reference model: advance one clock edge from the rules of the router.
    initial begin : model_proc
        logic rdy;
        logic anyp;
        forever begin
            @(posedge clk);
            if (rst_n === 1'b1) begin
                rdy  = exp_src_ready();
                anyp = 1'b0;
                for (int s = 0; s < N; s++) begin
                    if (bus.src_valid && rdy && mmask[s] != '0) begin
                        anyp     = 1'b1;
                        mdata[s] = load_word(mdata[s], bus.src_data, mmask[s]);
                        mvld[s]  = 1'b1;
                        exp_q[s].push_back(mdata[s]);
                    end else if (mvld[s] && bus.snk_ready[s]) begin
                        mvld[s] = 1'b0;
                    end
                end
                if (bus.src_valid && rdy && !anyp && mdrop != {DCW{1'b1}}) mdrop = mdrop + 1'b1;
                if (bus.cfg_we && int'(bus.cfg_sel) < N) mmask[bus.cfg_sel] = bus.cfg_mask;
            end
        end
    end

    // Monitor: compare DUT outputs with scoreboard on every falling edge.
    initial begin : monitor_proc
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                check("src_ready", 32'(bus.src_ready), 32'(exp_src_ready()));
                check("drop_count", 32'(bus.drop_count), 32'(mdrop));
                for (int s = 0; s < N; s++) begin
                    check($sformatf("snk_valid[%0d]", s), 32'(bus.snk_valid[s]),
                          32'(exp_q[s].size() != 0));
                    if (bus.snk_valid[s] && exp_q[s].size() != 0) begin
                        check($sformatf("snk_data[%0d]", s), 32'(bus.snk_data[s*W +: W]),
                              32'(exp_q[s][0]));
                        if (bus.snk_ready[s]) void'(exp_q[s].pop_front());
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] d, input logic [N-1:0] r,
                         input logic we, input logic [SW-1:0] sel, input logic [W-1:0] m);
        @(posedge clk);
        #1;
        bus.src_valid = v;
        bus.src_data  = d;
        bus.snk_ready = r;
        bus.cfg_we    = we;
        bus.cfg_sel   = sel;
        bus.cfg_mask  = m;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected end of run");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [N-1:0] rr;
        rst_n         = 1'b0;
        bus.src_valid = 1'b0;
        bus.src_data  = '0;
        bus.snk_ready = 2'b11;
        bus.cfg_we    = 1'b0;
        bus.cfg_sel   = '0;
        bus.cfg_mask  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst snk_valid", 32'(bus.snk_valid), 32'h0);
        check("rst snk_data", 32'(bus.snk_data), 32'h0);
        check("rst drop_count", 32'(bus.drop_count), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle src_ready", 32'(bus.src_ready), 32'h1);

        // Reset map routing
        drive(1, 2'b11, 2'b11, 0, 0, 0);
        drive(0, 2'b00, 2'b11, 0, 0, 0);
        @(negedge clk);
        check("map snk_valid", 32'(bus.snk_valid), 32'h3);
        check("map snk_data", 32'(bus.snk_data), 32'h6);

        // Backpressure on sink 0
        drive(1, 2'b11, 2'b10, 0, 0, 0);
        drive(1, 2'b00, 2'b10, 0, 0, 0);
        @(negedge clk);
        check("bp src_ready", 32'(bus.src_ready), 32'h0);
        drive(1, 2'b00, 2'b10, 0, 0, 0);
        @(negedge clk);
        check("bp held data0", 32'(bus.snk_data[1:0]), 32'h2);
        drive(1, 2'b00, 2'b11, 0, 0, 0);
        @(negedge clk);
        check("bp release src_ready", 32'(bus.src_ready), 32'h1);
        drive(0, 2'b00, 2'b01, 0, 0, 0);
        @(negedge clk);
        check("bp snk_valid", 32'(bus.snk_valid), 32'h3);
        check("bp snk_data", 32'(bus.snk_data), 32'h0);

        // Disable sink 1 while it is stalled with a pending word
        drive(0, 2'b00, 2'b01, 1, 1, 2'b00);
        @(negedge clk);
        check("cfg stalled src_ready", 32'(bus.src_ready), 32'h0);
        drive(1, 2'b11, 2'b01, 0, 0, 0);
        @(negedge clk);
        check("cfg unblocked src_ready", 32'(bus.src_ready), 32'h1);
        drive(0, 2'b00, 2'b01, 0, 0, 0);
        @(negedge clk);
        check("cfg snk_valid", 32'(bus.snk_valid), 32'h3);
        check("cfg snk_data", 32'(bus.snk_data), 32'h2);
        drive(0, 2'b00, 2'b11, 0, 0, 0);
        drive(0, 2'b00, 2'b11, 0, 0, 0);
        @(negedge clk);
        check("cfg drained", 32'(bus.snk_valid), 32'h0);

        // Hold vs zero-fill of unmasked bits
        drive(0, 2'b00, 2'b11, 1, 0, 2'b11);
        drive(1, 2'b01, 2'b11, 0, 0, 0);
        drive(0, 2'b00, 2'b11, 1, 0, 2'b10);
        @(negedge clk);
        check("fill prior data0", 32'(bus.snk_data[1:0]), 32'h1);
        drive(1, 2'b10, 2'b11, 0, 0, 0);
        drive(0, 2'b00, 2'b11, 0, 0, 0);
        @(negedge clk);
        check("fill data0", 32'(bus.snk_data[1:0]), ZF ? 32'h2 : 32'h3);

        // All masks zero: drops saturate
        drive(0, 2'b00, 2'b11, 1, 0, 2'b00);
        drive(1, W'($urandom), 2'b11, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive((i == 4) ? 1'b0 : 1'b1, W'($urandom), 2'b11, 0, 0, 0);
            @(negedge clk);
            check($sformatf("drop_count #%0d", i + 1), 32'(bus.drop_count),
                  (i + 1 > 3) ? 32'd3 : 32'(i + 1));
            check($sformatf("drop snk_valid #%0d", i + 1), 32'(bus.snk_valid), 32'h0);
        end

        // Overlapping masks with a config write alongside a transfer
        drive(0, 2'b00, 2'b11, 1, 0, 2'b11);
        drive(0, 2'b00, 2'b11, 1, 1, 2'b11);
        drive(1, 2'b10, 2'b11, 1, 0, 2'b01);
        drive(1, 2'b11, 2'b11, 0, 0, 0);
        @(negedge clk);
        check("overlap old mask", 32'(bus.snk_data), 32'hA);
        drive(0, 2'b00, 2'b11, 0, 0, 0);
        @(negedge clk);
        check("overlap new mask", 32'(bus.snk_data), ZF ? 32'hD : 32'hF);

        // Asynchronous reset with stalled words pending
        drive(1, 2'b01, 2'b00, 0, 0, 0);
        drive(0, 2'b00, 2'b00, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async rst snk_valid", 32'(bus.snk_valid), 32'h0);
        check("async rst snk_data", 32'(bus.snk_data), 32'h0);
        check("async rst drop_count", 32'(bus.drop_count), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1, 2'b11, 2'b11, 0, 0, 0);
        drive(0, 2'b00, 2'b11, 0, 0, 0);
        @(negedge clk);
        check("rst remap snk_data", 32'(bus.snk_data), 32'h6);

        // Randomized traffic, config churn and backpressure
        for (int i = 0; i < 400; i++) begin
            rr = '0;
            for (int s = 0; s < N; s++) rr[s] = ($urandom_range(0, 3) != 0);
            drive(1'($urandom_range(0, 1)), W'($urandom), rr,
                  ($urandom_range(0, 7) == 0), SW'($urandom_range(0, N - 1)), W'($urandom));
        end
        drive(0, 2'b00, 2'b11, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
